// File: rtl/s2c_pkg.sv
// Shared types and constants for the s2c call blocks.
package s2c_pkg;

    typedef enum logic [1:0] {
        S2C_IDLE    = 2'd0,
        S2C_ISSUE   = 2'd1,
        S2C_COLLECT = 2'd2,
        S2C_DELIVER = 2'd3
    } s2c_state_e;

    localparam logic [31:0] S2C_RET_TIMEOUT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] fn;
    } s2c_call_t;

    function automatic int s2c_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s2c_rr_arb.sv
// Combinational round-robin picker; the caller owns and updates the last-grant pointer.
module s2c_rr_arb #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NCH-1:0] gnt_onehot,
    output logic [IW-1:0]  gnt_idx
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [IW:0]      pos;
    logic             found;

    // Rotate so bit 0 is the channel just after last; the first set bit wins.
    assign dbl = {req, req} >> ({1'b0, last} + 1'b1);
    assign rot = dbl[NCH-1:0];

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        pos        = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = {1'b0, last} + (IW+1)'(k + 1);
                if (pos >= (IW+1)'(NCH)) begin
                    pos = pos - (IW+1)'(NCH);
                end
                gnt_idx    = pos[IW-1:0];
                gnt_onehot = NCH'(1) << pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/s2c_call_arb.sv
// Round-robin arbiter funnelling NCH call requesters onto one downstream call port,
// collecting a streamed response and returning it to the owning channel.
module s2c_call_arb
    import s2c_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DATA_WORDS = 8,
    parameter int WORD_W     = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCH-1:0]               ch_req_valid,
    output logic [NCH-1:0]               ch_req_ready,
    input  logic [NCH*32-1:0]            ch_req_id,
    input  logic [NCH*32-1:0]            ch_req_fn,
    output logic [NCH-1:0]               ch_rsp_valid,
    output logic [31:0]                  ch_rsp_ret,
    output logic [DATA_WORDS*WORD_W-1:0] ch_rsp_data,
    output logic                         ch_rsp_timeout,
    output logic                         ch_rsp_ovf,
    output logic                         call_valid,
    input  logic                         call_ready,
    output logic [31:0]                  call_id,
    output logic [31:0]                  call_fn,
    input  logic                         rsp_valid,
    input  logic                         rsp_last,
    input  logic [WORD_W-1:0]            rsp_word,
    input  logic [31:0]                  rsp_ret,
    output logic                         busy,
    output logic [s2c_idx_w(NCH)-1:0]    grant_ch
);

    localparam int GW = s2c_idx_w(NCH);
    localparam int CW = $clog2(DATA_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT);

    s2c_state_e state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  grant_q;
    s2c_call_t      call_q;
    s2c_call_t      pick_call;
    logic [NCH-1:0] gnt_onehot;
    logic [GW-1:0]  gnt_idx;
    logic           accept;

    logic [DATA_WORDS-1:0][WORD_W-1:0] wbuf;
    logic [DATA_WORDS-1:0][WORD_W-1:0] wbuf_nxt;
    logic [DATA_WORDS-1:0][WORD_W-1:0] out_data;
    logic          ovf_q;
    logic          ovf_nxt;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic          strobe;
    logic          last_strobe;
    logic          expire;
    logic [31:0]   out_ret;
    logic          out_to;
    logic          out_ovf;

    s2c_rr_arb #(
        .NCH (NCH),
        .IW  (GW)
    ) u_arb (
        .req        (ch_req_valid),
        .last       (last_grant),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign ch_req_ready = (state == S2C_IDLE && !rst) ? gnt_onehot : '0;
    assign accept       = |(ch_req_valid & ch_req_ready);

    always_comb begin
        pick_call = '0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (gnt_onehot[j]) begin
                pick_call.id = ch_req_id[32*j +: 32];
                pick_call.fn = ch_req_fn[32*j +: 32];
            end
        end
    end

    assign strobe      = (state == S2C_COLLECT) && rsp_valid;
    assign last_strobe = strobe && rsp_last;
    // A last strobe landing on the final timeout cycle takes precedence.
    assign expire      = (state == S2C_COLLECT) && !last_strobe && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        wbuf_nxt = wbuf;
        ovf_nxt  = ovf_q;
        if (strobe) begin
            for (int unsigned i = 0; i < DATA_WORDS; i++) begin
                if (cnt == CW'(i)) begin
                    wbuf_nxt[i] = rsp_word;
                end
            end
            if (cnt == CW'(DATA_WORDS)) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S2C_IDLE;
            last_grant <= GW'(NCH - 1);
            grant_q    <= '0;
            call_q     <= '0;
            wbuf       <= '0;
            ovf_q      <= 1'b0;
            cnt        <= '0;
            tcnt       <= '0;
            out_data   <= '0;
            out_ret    <= '0;
            out_to     <= 1'b0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                S2C_IDLE: begin
                    if (accept) begin
                        call_q  <= pick_call;
                        grant_q <= gnt_idx;
                        wbuf    <= '0;
                        ovf_q   <= 1'b0;
                        state   <= S2C_ISSUE;
                    end
                end
                S2C_ISSUE: begin
                    if (call_ready) begin
                        cnt   <= '0;
                        tcnt  <= '0;
                        state <= S2C_COLLECT;
                    end
                end
                S2C_COLLECT: begin
                    wbuf  <= wbuf_nxt;
                    ovf_q <= ovf_nxt;
                    if (strobe && cnt < CW'(DATA_WORDS)) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (!expire) begin
                        tcnt <= tcnt + 1'b1;
                    end
                    // Results land in separate output registers so they stay stable until the next delivery.
                    if (last_strobe || expire) begin
                        out_data <= wbuf_nxt;
                        out_ovf  <= ovf_nxt;
                        out_ret  <= last_strobe ? rsp_ret : S2C_RET_TIMEOUT;
                        out_to   <= !last_strobe;
                        state    <= S2C_DELIVER;
                    end
                end
                S2C_DELIVER: begin
                    last_grant <= grant_q;
                    state      <= S2C_IDLE;
                end
                default: state <= S2C_IDLE;
            endcase
        end
    end

    assign ch_rsp_valid   = (state == S2C_DELIVER) ? (NCH'(1) << grant_q) : '0;
    assign ch_rsp_ret     = out_ret;
    assign ch_rsp_data    = out_data;
    assign ch_rsp_timeout = out_to;
    assign ch_rsp_ovf     = out_ovf;
    assign call_valid     = (state == S2C_ISSUE);
    assign call_id        = call_q.id;
    assign call_fn        = call_q.fn;
    assign busy           = (state != S2C_IDLE);
    assign grant_ch       = grant_q;

endmodule

// File: tb/tb_s2c_call_arb.sv
// Self-checking bench for s2c_call_arb: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_s2c_call_arb;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int WW  = 32;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   ch_req_valid;
    logic [NCH-1:0]   ch_req_ready;
    logic [NCH*32-1:0] ch_req_id;
    logic [NCH*32-1:0] ch_req_fn;
    logic [NCH-1:0]   ch_rsp_valid;
    logic [31:0]      ch_rsp_ret;
    logic [DW*WW-1:0] ch_rsp_data;
    logic             ch_rsp_timeout;
    logic             ch_rsp_ovf;
    logic             call_valid;
    logic             call_ready;
    logic [31:0]      call_id;
    logic [31:0]      call_fn;
    logic             rsp_valid;
    logic             rsp_last;
    logic [WW-1:0]    rsp_word;
    logic [31:0]      rsp_ret;
    logic             busy;
    logic [1:0]       grant_ch;

    s2c_call_arb #(
        .NCH        (NCH),
        .DATA_WORDS (DW),
        .WORD_W     (WW),
        .TIMEOUT    (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_req_valid   (ch_req_valid),
        .ch_req_ready   (ch_req_ready),
        .ch_req_id      (ch_req_id),
        .ch_req_fn      (ch_req_fn),
        .ch_rsp_valid   (ch_rsp_valid),
        .ch_rsp_ret     (ch_rsp_ret),
        .ch_rsp_data    (ch_rsp_data),
        .ch_rsp_timeout (ch_rsp_timeout),
        .ch_rsp_ovf     (ch_rsp_ovf),
        .call_valid     (call_valid),
        .call_ready     (call_ready),
        .call_id        (call_id),
        .call_fn        (call_fn),
        .rsp_valid      (rsp_valid),
        .rsp_last       (rsp_last),
        .rsp_word       (rsp_word),
        .rsp_ret        (rsp_ret),
        .busy           (busy),
        .grant_ch       (grant_ch)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t: wait bound expired", nm, $time);
    endtask

    // ---------------- downstream responder ----------------
    bit          rand_plan = 0;
    int          plan_delay = 0;
    int          plan_n = 1;
    int          plan_gapmax = 0;
    bit          plan_silent = 0;
    logic [31:0] plan_ret = '0;
    logic [31:0] plan_w [0:15];

    initial begin
        call_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_last   = 1'b0;
        rsp_word   = '0;
        rsp_ret    = '0;
        forever begin
            @(posedge clk); #1;
            if (call_valid && !rst) begin
                if (rand_plan) begin
                    plan_delay  = $urandom % 5;
                    plan_silent = ($urandom % 12) == 0;
                    plan_n      = 1 + $urandom % 11;
                    plan_gapmax = 2;
                    plan_ret    = $urandom;
                    for (int i = 0; i < 16; i++) plan_w[i] = $urandom;
                end
                repeat (plan_delay) begin @(posedge clk); #1; end
                call_ready = 1'b1;
                @(posedge clk); #1;
                call_ready = 1'b0;
                rsp_valid  = 1'b0;
                rsp_last   = 1'b0;
                if (plan_silent) begin
                    while (busy && !rst) begin @(posedge clk); #1; end
                end else begin
                    for (int w = 0; w < plan_n; w++) begin
                        rsp_valid = 1'b0;
                        rsp_last  = 1'b0;
                        repeat ((plan_gapmax > 0) ? ($urandom % (plan_gapmax + 1)) : 0) begin
                            @(posedge clk); #1;
                        end
                        rsp_valid = 1'b1;
                        rsp_word  = plan_w[w];
                        rsp_last  = (w == plan_n - 1);
                        rsp_ret   = plan_ret;
                        @(posedge clk); #1;
                    end
                    rsp_valid = 1'b0;
                    rsp_last  = 1'b0;
                end
            end else begin
                // Strobes while no call is collecting must be ignored.
                rsp_valid = $urandom % 2;
                rsp_last  = $urandom % 2;
                rsp_word  = $urandom;
                rsp_ret   = $urandom;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    int          owner;
    bit          issued;
    bit          pend;
    int          m_last;
    int          hs_cyc;
    int          cyc = 0;
    logic [31:0] words [$];
    logic [NCH-1:0] acc_mask;
    logic [31:0] e_id, e_fn, e_ret;
    logic [DW*WW-1:0] e_data;
    logic        e_to, e_ovf;
    logic [1:0]  e_grant;

    function automatic int rr_pick(input logic [NCH-1:0] v, input int last);
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (last + k) % NCH;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW*WW-1:0] pack_words();
        logic [DW*WW-1:0] r;
        r = '0;
        for (int i = 0; i < DW && i < words.size(); i++) r[WW*i +: WW] = words[i];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1; issued = 0; pend = 0; m_last = NCH - 1;
            e_id = '0; e_fn = '0; e_ret = '0; e_data = '0; e_to = 0; e_ovf = 0; e_grant = '0;
            acc_mask = '0;
            words.delete();
        end else begin
            int p;
            cyc++;
            acc_mask = '0;
            if (pend) begin
                m_last = owner;
                owner  = -1;
                pend   = 0;
            end else if (owner < 0) begin
                p = rr_pick(ch_req_valid, m_last);
                if (p >= 0) begin
                    owner = p;
                    acc_mask[p] = 1'b1;
                    e_grant = 2'(p);
                    e_id = ch_req_id[32*p +: 32];
                    e_fn = ch_req_fn[32*p +: 32];
                    issued = 0;
                    words.delete();
                end
            end else if (!issued) begin
                if (call_ready) begin
                    issued = 1;
                    hs_cyc = cyc;
                end
            end else begin
                if (rsp_valid) words.push_back(rsp_word);
                if (rsp_valid && rsp_last) begin
                    e_data = pack_words(); e_ovf = words.size() > DW;
                    e_ret = rsp_ret; e_to = 0; pend = 1;
                end else if (cyc == hs_cyc + TO) begin
                    e_data = pack_words(); e_ovf = words.size() > DW;
                    e_ret = 32'hFFFF_FFFF; e_to = 1; pend = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [NCH-1:0] e_ready;
        logic [NCH-1:0] e_pulse;
        int p;
        e_ready = '0;
        if (!rst && owner < 0) begin
            p = rr_pick(ch_req_valid, m_last);
            if (p >= 0) e_ready[p] = 1'b1;
        end
        e_pulse = '0;
        if (pend) e_pulse[owner] = 1'b1;
        chk("ch_req_ready", ch_req_ready, e_ready);
        chk("busy", busy, owner >= 0);
        chk("call_valid", call_valid, owner >= 0 && !issued);
        chk("call_id", call_id, e_id);
        chk("call_fn", call_fn, e_fn);
        chk("grant_ch", grant_ch, e_grant);
        chk("ch_rsp_valid", ch_rsp_valid, e_pulse);
        chk("ch_rsp_ret", ch_rsp_ret, e_ret);
        chk("ch_rsp_data", ch_rsp_data, e_data);
        chk("ch_rsp_timeout", ch_rsp_timeout, e_to);
        chk("ch_rsp_ovf", ch_rsp_ovf, e_ovf);
    end

    // ---------------- directed helpers ----------------
    task automatic do_req(input int ch, input logic [31:0] id, input logic [31:0] fn);
        bit ok;
        @(posedge clk); #1;
        ch_req_valid[ch]      = 1'b1;
        ch_req_id[32*ch +: 32] = id;
        ch_req_fn[32*ch +: 32] = fn;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (ch_req_ready[ch]) ok = 1;
        end
        if (!ok) bound_fail("req_accept");
        @(posedge clk); #1;
        ch_req_valid[ch] = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        bit ok;
        ok = 0;
        n  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ch_rsp_valid != '0) ok = 1;
            else n++;
        end
        if (!ok) bound_fail("rsp_pulse");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        if (!ok) bound_fail("idle");
    endtask

    task automatic wait_handshake();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (call_valid && call_ready) ok = 1;
        end
        if (!ok) bound_fail("handshake");
    endtask

    task automatic set_plan(input int delay, input int n, input bit silent, input logic [31:0] ret, input logic [31:0] base);
        plan_delay  = delay;
        plan_n      = n;
        plan_silent = silent;
        plan_ret    = ret;
        plan_gapmax = 0;
        for (int i = 0; i < 16; i++) plan_w[i] = base + 32'(i);
    endtask

    initial begin
        #500000;
        bound_fail("global_watchdog");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int n;
        int seq [5];
        int got;
        int cvcnt;
        int exp_seq [5];
        logic [255:0] tmp;

        rst = 1'b1;
        ch_req_valid = '0;
        ch_req_id = '0;
        ch_req_fn = '0;
        for (int i = 0; i < 16; i++) plan_w[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_call_valid", call_valid, 1'b0);
        chk("rst_rsp_valid", ch_rsp_valid, 4'b0000);
        chk("rst_data", ch_rsp_data, '0);
        chk("rst_grant", grant_ch, 2'd0);

        // Single call on ch2: three words, ret 0
        set_plan(0, 3, 0, 32'h0, 32'h0);
        plan_w[0] = 32'hA; plan_w[1] = 32'hB; plan_w[2] = 32'hC;
        do_req(2, 32'd5, 32'd1);
        @(negedge clk);
        chk("single_call_valid", call_valid, 1'b1);
        chk("single_call_id", call_id, 32'd5);
        chk("single_call_fn", call_fn, 32'd1);
        wait_pulse(n);
        chk("single_rsp_valid", ch_rsp_valid, 4'b0100);
        chk("single_word0", ch_rsp_data[31:0], 32'hA);
        chk("single_word1", ch_rsp_data[63:32], 32'hB);
        chk("single_word2", ch_rsp_data[95:64], 32'hC);
        tmp = ch_rsp_data >> 96;
        chk("single_words3_7", tmp, '0);
        chk("single_ret", ch_rsp_ret, 32'h0);
        wait_idle();

        // Fairness: all four request continuously; last grant was ch2
        set_plan(0, 1, 0, 32'h77, 32'h500);
        exp_seq = '{3, 0, 1, 2, 3};
        @(posedge clk); #1;
        ch_req_valid = 4'hF;
        for (int k = 0; k < NCH; k++) ch_req_id[32*k +: 32] = 32'(100 + k);
        got = 0;
        for (int i = 0; i < 400 && got < 5; i++) begin
            @(negedge clk);
            if (ch_req_ready != '0) begin
                for (int k = 0; k < NCH; k++) if (ch_req_ready[k]) seq[got] = k;
                got++;
                @(posedge clk); #1;
                ch_req_id[32*seq[got-1] +: 32] = $urandom;
                if (got == 5) ch_req_valid = '0;
            end
        end
        if (got < 5) begin
            bound_fail("fair_grants");
            ch_req_valid = '0;
        end
        for (int i = 0; i < got; i++) chk($sformatf("fair_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        wait_idle();

        // Backpressure: call_ready withheld for 10 cycles
        set_plan(10, 2, 0, 32'h42, 32'h900);
        do_req(0, 32'hDEAD, 32'hBEEF);
        cvcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!call_valid) break;
            cvcnt++;
        end
        chk("bp_call_valid_cycles", 32'(cvcnt), 32'd11);
        wait_pulse(n);
        chk("bp_rsp_valid", ch_rsp_valid, 4'b0001);
        wait_idle();

        // Overflow: 10 words into 8 slots
        set_plan(0, 10, 0, 32'h1234, 32'd100);
        do_req(1, 32'h11, 32'h22);
        wait_pulse(n);
        chk("ovf_flag", ch_rsp_ovf, 1'b1);
        chk("ovf_word0", ch_rsp_data[31:0], 32'd100);
        chk("ovf_word7", ch_rsp_data[255:224], 32'd107);
        chk("ovf_ret", ch_rsp_ret, 32'h1234);
        chk("ovf_timeout", ch_rsp_timeout, 1'b0);
        wait_idle();

        // Timeout: silent source
        set_plan(0, 1, 1, 32'h0, 32'h0);
        do_req(2, 32'h33, 32'h44);
        wait_handshake();
        wait_pulse(n);
        chk("to_latency", 32'(n), 32'd16);
        chk("to_ret", ch_rsp_ret, 32'hFFFF_FFFF);
        chk("to_flag", ch_rsp_timeout, 1'b1);
        chk("to_rsp_valid", ch_rsp_valid, 4'b0100);
        wait_idle();

        // Reset mid-COLLECT, then a clean call on ch1
        set_plan(0, 1, 1, 32'h0, 32'h0);
        do_req(3, 32'h55, 32'h66);
        wait_handshake();
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rsp_valid", ch_rsp_valid, 4'b0000);
        chk("mid_rst_data", ch_rsp_data, '0);
        chk("mid_rst_ret", ch_rsp_ret, 32'h0);
        chk("mid_rst_call_id", call_id, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_plan(0, 2, 0, 32'h9, 32'hC0);
        do_req(1, 32'h77, 32'h88);
        wait_pulse(n);
        chk("post_rst_rsp_valid", ch_rsp_valid, 4'b0010);
        chk("post_rst_word0", ch_rsp_data[31:0], 32'hC0);
        chk("post_rst_word1", ch_rsp_data[63:32], 32'hC1);
        tmp = ch_rsp_data >> 64;
        chk("post_rst_clean", tmp, '0);
        chk("post_rst_ret", ch_rsp_ret, 32'h9);
        wait_idle();

        // Randomized traffic
        rand_plan = 1;
        repeat (3000) begin
            @(posedge clk); #1;
            for (int k = 0; k < NCH; k++) begin
                if (!ch_req_valid[k] || acc_mask[k]) begin
                    ch_req_valid[k] = ($urandom % 4) == 0;
                    ch_req_id[32*k +: 32] = $urandom;
                    ch_req_fn[32*k +: 32] = $urandom;
                end else if (($urandom % 16) == 0) begin
                    ch_req_valid[k] = 1'b0;
                end
            end
        end
        ch_req_valid = '0;
        wait_idle();
        repeat (40) @(negedge clk);
        rand_plan = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
